cpu5_mcctrl: RTL and testbench
==============================

# cpu5_mcctrl

Multicycle control sequencer for the cpu5 core. It sits between `cpu5_maindec` and the shared datapath: one ALU, one register file and one unified instruction/data memory port. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, drives every datapath mux select and write strobe, and owns the req/ack handshake of the single memory port. Undecoded or unsupported instructions and memory timeouts send it to a sticky FAULT state.

## Interface

Parameters:
- TIMEOUT_CYCLES, default 255: maximum wait cycles for `mem_ack` while `mem_req` is high. A value of 0 disables the timeout.

Ports:
- clk  in  1  core clock; the only clock.
- resetn  in  1  reset, synchronous and active-low.
- memtoreg, memwrite, alusrc, regwrite, jump  in  1 each  decoder control fields, held stable from DECODE through WB.
- branchtype  in  `CPU5_BRANCHTYPE_SIZE`  decoder branch type: `CPU5_BRANCHTYPE_NOBRANCH`, `_BEQ` or `_BNE`.
- aluop  in  `CPU5_ALU_OP_SIZE`  decoder ALU op: 00 add, 01 sub.
- dec_valid  in  1  decoder recognised the instruction in IR.
- alu_zero  in  1  current ALU result is zero.
- mem_ack  in  1  memory accepts/completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_iord  out  1  memory address source: 0 = PC, 1 = ALUOut.
- ir_we  out  1  latch IR and OLDPC (PC of the fetched instruction).
- pc_we  out  1  PC write enable.
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- alu_srca  out  2  ALU A input: 00 = PC, 01 = OLDPC, 10 = rs1.
- alu_srcb  out  2  ALU B input: 00 = rs2, 01 = constant 4, 10 = imm.
- alu_op  out  `CPU5_ALU_OP_SIZE`  ALU operation.
- rf_we  out  1  register file write.
- rf_wsel  out  1  write-back source: 0 = ALUOut, 1 = MDR.
- retire  out  1  one-cycle pulse when an instruction completes.
- fault  out  1  sticky fault flag.
- state  out  3  current state, for debug.

## Operation

State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, FAULT = 7. Codes 5 and 6 are illegal and go to FAULT on the next clock.

Datapath contract: ALUOut latches the ALU result every cycle; MDR latches memory read data when `mem_ack` is high.

Unless a state below says otherwise, outputs default to strobes 0, `alu_srca` = 00, `alu_srcb` = 00, `alu_op` = 00.

- **FETCH**
  - `mem_req` = 1, `mem_iord` = 0, `mem_we` = 0.
  - On `mem_ack`: `ir_we` = 1 and `pc_we` = 1, with `pc_src` = 0, `alu_srca` = 00, `alu_srcb` = 01, `alu_op` = add (PC ← PC+4); go to DECODE.
- **DECODE**
  - `alu_srca` = 01, `alu_srcb` = 10, `alu_op` = add, so ALUOut ← OLDPC + imm (branch target).
  - If `dec_valid` = 0 or `jump` = 1 → FAULT; otherwise → EXEC.
- **EXEC**
  - Branch (`branchtype` ≠ NOBRANCH): `alu_srca` = 10, `alu_srcb` = 00, `alu_op` = `aluop`. `taken` = (BEQ & `alu_zero`) | (BNE & !`alu_zero`). `pc_we` = `taken`, `pc_src` = 1. `retire` = 1. Go to FETCH.
  - Load/store (`memtoreg` | `memwrite`): `alu_srca` = 10, `alu_srcb` = 10, `alu_op` = add. Go to MEM.
  - Otherwise (ALU op): `alu_srca` = 10, `alu_srcb` = `alusrc` ? 10 : 00, `alu_op` = `aluop`. Go to WB.
- **MEM**
  - `mem_req` = 1, `mem_iord` = 1, `mem_we` = `memwrite`.
  - On `mem_ack`: if `memtoreg` → WB; otherwise `retire` = 1 → FETCH.
- **WB**
  - `rf_we` = `regwrite`, `rf_wsel` = `memtoreg`, `retire` = 1. Go to FETCH.
- **FAULT**
  - All strobes are 0 and `fault` = 1. The block stays in FAULT until reset.

Timeout counter:
- 8-bit minimum width, enough to hold TIMEOUT_CYCLES.
- Cleared on entry to FETCH or MEM; increments each cycle `mem_req` = 1 and `mem_ack` = 0.
- When it reaches TIMEOUT_CYCLES with no ack → FAULT.

## Timing

- Reset: while `resetn` = 0 at a clock edge, state ← FETCH, the counter is cleared and `fault` ← 0.
  - While `resetn` is sampled low, all outputs are forced to 0; this overrides FETCH's `mem_req`.
  - The first request is issued in the first cycle after `resetn` is sampled high.
- Reset mid-operation (any state, including FAULT or an outstanding request) returns to FETCH next cycle. No strobe fires in the reset cycle.
- Outputs are combinational from state and inputs. `ir_we`, `pc_we` (FETCH), `retire` (MEM) and the MEM→WB transition are qualified by `mem_ack` in the same cycle.
- Handshake:
  - `mem_req`, `mem_iord` and `mem_we` stay stable until the cycle `mem_ack` is seen.
  - `mem_ack` while `mem_req` = 0 is ignored.
  - Exactly one transfer occurs per ack.
- Ack in the same cycle the counter reaches TIMEOUT_CYCLES: the ack wins and normal progress continues.
- Latency with zero-wait memory (ack in the request cycle):
  - ALU op: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Each memory wait cycle adds 1.

## Test plan

- ADD/ADDI with `mem_ack` tied 1 → states 0,1,2,4 repeat; `rf_we` high only in WB; `retire` every 4th cycle; ADDI drives `alu_srcb` = 10 in EXEC.
- LW with data ack after 3 wait cycles → `mem_req` held 4 cycles in MEM with `mem_iord` = 1 and `mem_we` = 0; WB with `rf_wsel` = 1 follows. SW → `mem_we` = 1, no WB, `retire` in the MEM ack cycle.
- BEQ with `alu_zero` = 1 → `pc_we` = 1, `pc_src` = 1 in EXEC. BEQ with `alu_zero` = 0 → `pc_we` = 0. BNE → the inverse. Each completes in 3 cycles.
- `dec_valid` = 0, or `jump` = 1, in DECODE → FAULT next cycle; `fault` = 1 and no strobes for 20 cycles; `resetn` low for 1 cycle → FETCH with `mem_req` = 1 in the first cycle after release.
- TIMEOUT_CYCLES = 4, no ack → FAULT after 4 wait cycles. Ack in the 4th wait cycle (the cycle the counter reaches 4) → DECODE, no fault. TIMEOUT_CYCLES = 0 with no ack for 1000 cycles → still in FETCH.
- `resetn` asserted during MEM with a pending ack → no `rf_we`, `retire` or `mem_we` in the reset cycle; state = 0 afterwards.

Source files
------------

// File: rtl/cpu5_mcctrl_if.sv
// rtl/cpu5_mcctrl_if.sv - decoder, memory-port and datapath-control bundle for cpu5_mcctrl
`ifndef CPU5_ALU_OP_SIZE
`define CPU5_ALU_OP_SIZE 2
`endif
`ifndef CPU5_BRANCHTYPE_SIZE
`define CPU5_BRANCHTYPE_SIZE 2
`endif
`ifndef CPU5_BRANCHTYPE_NOBRANCH
`define CPU5_BRANCHTYPE_NOBRANCH 2'd0
`endif
`ifndef CPU5_BRANCHTYPE_BEQ
`define CPU5_BRANCHTYPE_BEQ 2'd1
`endif
`ifndef CPU5_BRANCHTYPE_BNE
`define CPU5_BRANCHTYPE_BNE 2'd2
`endif

interface cpu5_mcctrl_if;
    logic                              memtoreg;
    logic                              memwrite;
    logic                              alusrc;
    logic                              regwrite;
    logic                              jump;
    logic [`CPU5_BRANCHTYPE_SIZE-1:0]  branchtype;
    logic [`CPU5_ALU_OP_SIZE-1:0]      aluop;
    logic                              dec_valid;
    logic                              alu_zero;
    logic                              mem_ack;
    logic                              mem_req;
    logic                              mem_we;
    logic                              mem_iord;
    logic                              ir_we;
    logic                              pc_we;
    logic                              pc_src;
    logic [1:0]                        alu_srca;
    logic [1:0]                        alu_srcb;
    logic [`CPU5_ALU_OP_SIZE-1:0]      alu_op;
    logic                              rf_we;
    logic                              rf_wsel;
    logic                              retire;
    logic                              fault;
    logic [2:0]                        state;

    modport master (
        input  memtoreg, memwrite, alusrc, regwrite, jump, branchtype, aluop,
               dec_valid, alu_zero, mem_ack,
        output mem_req, mem_we, mem_iord, ir_we, pc_we, pc_src, alu_srca,
               alu_srcb, alu_op, rf_we, rf_wsel, retire, fault, state
    );

    modport slave (
        output memtoreg, memwrite, alusrc, regwrite, jump, branchtype, aluop,
               dec_valid, alu_zero, mem_ack,
        input  mem_req, mem_we, mem_iord, ir_we, pc_we, pc_src, alu_srca,
               alu_srcb, alu_op, rf_we, rf_wsel, retire, fault, state
    );
endinterface

// File: rtl/cpu5_mcctrl.sv
// rtl/cpu5_mcctrl.sv - cpu5 multicycle sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshake and sticky FAULT
`ifndef CPU5_ALU_OP_SIZE
`define CPU5_ALU_OP_SIZE 2
`endif
`ifndef CPU5_BRANCHTYPE_SIZE
`define CPU5_BRANCHTYPE_SIZE 2
`endif
`ifndef CPU5_BRANCHTYPE_NOBRANCH
`define CPU5_BRANCHTYPE_NOBRANCH 2'd0
`endif
`ifndef CPU5_BRANCHTYPE_BEQ
`define CPU5_BRANCHTYPE_BEQ 2'd1
`endif
`ifndef CPU5_BRANCHTYPE_BNE
`define CPU5_BRANCHTYPE_BNE 2'd2
`endif

module cpu5_mcctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          resetn,
    cpu5_mcctrl_if.master bus
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd7;

    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam bit                TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             req_state;
    logic             timeout_hit;
    logic             is_branch;
    logic             is_ldst;
    logic             taken;

    assign req_state = (state_q == S_FETCH) || (state_q == S_MEM);
    // The last unacknowledged wait cycle is the one that would bring the count to TIMEOUT_CYCLES;
    // an ack in that same cycle still wins because the transition checks mem_ack first.
    assign timeout_hit = TO_EN && req_state && !bus.mem_ack && (cnt_q == TO_LAST);
    assign is_branch   = (bus.branchtype != `CPU5_BRANCHTYPE_NOBRANCH);
    assign is_ldst     = bus.memtoreg || bus.memwrite;
    assign taken       = ((bus.branchtype == `CPU5_BRANCHTYPE_BEQ) &&  bus.alu_zero) ||
                         ((bus.branchtype == `CPU5_BRANCHTYPE_BNE) && !bus.alu_zero);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
            cnt_q <= '0;
        end else if (req_state && !bus.mem_ack) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ack) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: state_d = (!bus.dec_valid || bus.jump) ? S_FAULT : S_EXEC;
            S_EXEC: begin
                if (is_branch) begin
                    state_d = S_FETCH;
                end else if (is_ldst) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (bus.mem_ack) begin
                    state_d = bus.memtoreg ? S_WB : S_FETCH;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    // Every output is held at zero while reset is sampled low, including FETCH's request.
    always_comb begin
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_iord = 1'b0;
        bus.ir_we    = 1'b0;
        bus.pc_we    = 1'b0;
        bus.pc_src   = 1'b0;
        bus.alu_srca = 2'b00;
        bus.alu_srcb = 2'b00;
        bus.alu_op   = '0;
        bus.rf_we    = 1'b0;
        bus.rf_wsel  = 1'b0;
        bus.retire   = 1'b0;
        bus.fault    = 1'b0;
        bus.state    = 3'd0;
        if (resetn) begin
            bus.state = state_q;
            case (state_q)
                S_FETCH: begin
                    bus.mem_req = 1'b1;
                    if (bus.mem_ack) begin
                        bus.ir_we    = 1'b1;
                        bus.pc_we    = 1'b1;
                        bus.alu_srcb = SRCB_FOUR;
                    end
                end
                S_DECODE: begin
                    bus.alu_srca = SRCA_OLDPC;
                    bus.alu_srcb = SRCB_IMM;
                end
                S_EXEC: begin
                    bus.alu_srca = SRCA_RS1;
                    if (is_branch) begin
                        bus.alu_srcb = SRCB_RS2;
                        bus.alu_op   = bus.aluop;
                        bus.pc_we    = taken;
                        bus.pc_src   = 1'b1;
                        bus.retire   = 1'b1;
                    end else if (is_ldst) begin
                        bus.alu_srcb = SRCB_IMM;
                    end else begin
                        bus.alu_srcb = bus.alusrc ? SRCB_IMM : SRCB_RS2;
                        bus.alu_op   = bus.aluop;
                    end
                end
                S_MEM: begin
                    bus.mem_req  = 1'b1;
                    bus.mem_iord = 1'b1;
                    bus.mem_we   = bus.memwrite;
                    bus.retire   = bus.mem_ack && !bus.memtoreg;
                end
                S_WB: begin
                    bus.rf_we   = bus.regwrite;
                    bus.rf_wsel = bus.memtoreg;
                    bus.retire  = 1'b1;
                end
                S_FAULT: bus.fault = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu5_mcctrl.sv
// tb/tb_cpu5_mcctrl.sv - scoreboard bench for cpu5_mcctrl
module tb_cpu5_mcctrl;
    logic clk = 1'b0;
    logic resetn;
    logic resetn0;

    cpu5_mcctrl_if bus();
    cpu5_mcctrl_if bus0();

    cpu5_mcctrl #(.TIMEOUT_CYCLES(4)) dut  (.clk(clk), .resetn(resetn),  .bus(bus.master));
    cpu5_mcctrl #(.TIMEOUT_CYCLES(0)) dut0 (.clk(clk), .resetn(resetn0), .bus(bus0.master));

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    logic [18:0] exp_q[$];

    // {dec_valid, memtoreg, memwrite, alusrc, regwrite, jump, branchtype, aluop}
    localparam logic [9:0] I_ADD  = 10'b1_0_0_0_1_0_00_00;
    localparam logic [9:0] I_ADDI = 10'b1_0_0_1_1_0_00_00;
    localparam logic [9:0] I_LW   = 10'b1_1_0_1_1_0_00_00;
    localparam logic [9:0] I_SW   = 10'b1_0_1_1_0_0_00_00;
    localparam logic [9:0] I_BEQ  = 10'b1_0_0_0_0_0_01_01;
    localparam logic [9:0] I_BNE  = 10'b1_0_0_0_0_0_10_01;
    localparam logic [9:0] I_BAD  = 10'b0_0_0_0_1_0_00_00;
    localparam logic [9:0] I_JMP  = 10'b1_0_0_0_1_1_00_00;

    function automatic logic [18:0] ev(input int st, input int req, input int we, input int iord,
                                       input int irwe, input int pcwe, input int pcsrc, input int sa,
                                       input int sb, input int op, input int rfwe, input int rfwsel,
                                       input int ret, input int flt);
        return {3'(st), 1'(req), 1'(we), 1'(iord), 1'(irwe), 1'(pcwe), 1'(pcsrc), 2'(sa), 2'(sb),
                2'(op), 1'(rfwe), 1'(rfwsel), 1'(ret), 1'(flt)};
    endfunction

    function automatic logic [18:0] v_fetch(input int ack);
        return ev(0, 1, 0, 0, ack, ack, 0, 0, ack, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic [18:0] v_dec();
        return ev(1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic [18:0] v_fault();
        return ev(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endfunction

    function automatic logic [18:0] obs();
        return {bus.state, bus.mem_req, bus.mem_we, bus.mem_iord, bus.ir_we, bus.pc_we, bus.pc_src,
                bus.alu_srca, bus.alu_srcb, bus.alu_op, bus.rf_we, bus.rf_wsel, bus.retire, bus.fault};
    endfunction

    function automatic logic [18:0] obs0();
        return {bus0.state, bus0.mem_req, bus0.mem_we, bus0.mem_iord, bus0.ir_we, bus0.pc_we, bus0.pc_src,
                bus0.alu_srca, bus0.alu_srcb, bus0.alu_op, bus0.rf_we, bus0.rf_wsel, bus0.retire, bus0.fault};
    endfunction

    task automatic set_instr(input logic [9:0] i);
        {bus.dec_valid, bus.memtoreg, bus.memwrite, bus.alusrc, bus.regwrite, bus.jump,
         bus.branchtype, bus.aluop} = i;
    endtask

    task automatic test_reset();
        logic [18:0] e, got;
        set_instr(I_ADD);
        for (int c = 0; c < 3; c++) begin
            resetn      = (c == 2);
            bus.mem_ack = (c == 1);
            e = (c == 2) ? v_fetch(0) : 19'd0;
            exp_q.push_back(e);
            @(negedge clk);
            got = obs();
            e = exp_q.pop_front();
            compared++;
            if (got !== e) begin mismatched++; $display("FAIL reset[%0d] got %h expected %h", c, got, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu();
        logic [18:0] e, got;
        for (int k = 0; k < 2; k++) begin
            set_instr(k == 0 ? I_ADD : I_ADDI);
            for (int c = 0; c < 4; c++) begin
                bus.mem_ack = 1'b1;
                case (c)
                    0:       e = v_fetch(1);
                    1:       e = v_dec();
                    2:       e = ev(2, 0, 0, 0, 0, 0, 0, 2, (k == 0) ? 0 : 2, 0, 0, 0, 0, 0);
                    default: e = ev(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
                endcase
                exp_q.push_back(e);
                @(negedge clk);
                got = obs();
                e = exp_q.pop_front();
                compared++;
                if (got !== e) begin mismatched++; $display("FAIL alu%0d[%0d] got %h expected %h", k, c, got, e); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_load_store();
        logic [18:0] e, got;
        set_instr(I_LW);
        for (int c = 0; c < 8; c++) begin
            bus.mem_ack = !(c >= 3 && c <= 5);
            case (c)
                0:       e = v_fetch(1);
                1:       e = v_dec();
                2:       e = ev(2, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0);
                3, 4, 5, 6: e = ev(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                default: e = ev(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
            endcase
            exp_q.push_back(e);
            @(negedge clk);
            got = obs();
            e = exp_q.pop_front();
            compared++;
            if (got !== e) begin mismatched++; $display("FAIL lw[%0d] got %h expected %h", c, got, e); end
            @(posedge clk); #1;
        end
        set_instr(I_SW);
        for (int c = 0; c < 5; c++) begin
            bus.mem_ack = 1'b1;
            case (c)
                0, 4:    e = v_fetch(1);
                1:       e = v_dec();
                2:       e = ev(2, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0);
                default: e = ev(3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            endcase
            if (c == 4) set_instr(I_ADD);
            exp_q.push_back(e);
            @(negedge clk);
            got = obs();
            e = exp_q.pop_front();
            compared++;
            if (got !== e) begin mismatched++; $display("FAIL sw[%0d] got %h expected %h", c, got, e); end
            @(posedge clk); #1;
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        logic [18:0] e, got;
        logic [3:0] exp_taken = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            set_instr(k < 2 ? I_BEQ : I_BNE);
            bus.alu_zero = (k == 0 || k == 2);
            for (int c = 0; c < 3; c++) begin
                bus.mem_ack = 1'b1;
                case (c)
                    0:       e = v_fetch(1);
                    1:       e = v_dec();
                    default: e = ev(2, 0, 0, 0, 0, int'(exp_taken[3-k]), 1, 2, 0, 1, 0, 0, 1, 0);
                endcase
                exp_q.push_back(e);
                @(negedge clk);
                got = obs();
                e = exp_q.pop_front();
                compared++;
                if (got !== e) begin mismatched++; $display("FAIL branch%0d[%0d] got %h expected %h", k, c, got, e); end
                @(posedge clk); #1;
            end
        end
        bus.alu_zero = 1'b0;
    endtask

    task automatic test_fault();
        logic [18:0] e, got;
        for (int k = 0; k < 2; k++) begin
            set_instr(k == 0 ? I_BAD : I_JMP);
            for (int c = 0; c < 24; c++) begin
                resetn      = (c != 22);
                bus.mem_ack = (c < 22) ? ((c == 0) ? 1'b1 : 1'(c[0])) : 1'b0;
                if (c == 0)       e = v_fetch(1);
                else if (c == 1)  e = v_dec();
                else if (c < 22)  e = v_fault();
                else if (c == 22) e = 19'd0;
                else              e = v_fetch(0);
                exp_q.push_back(e);
                @(negedge clk);
                got = obs();
                e = exp_q.pop_front();
                compared++;
                if (got !== e) begin mismatched++; $display("FAIL fault%0d[%0d] got %h expected %h", k, c, got, e); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_timeout();
        logic [18:0] e, got;
        set_instr(I_ADD);
        for (int c = 0; c < 24; c++) begin
            resetn      = !(c == 0 || c == 6 || c == 22);
            bus.mem_ack = (c == 10 || c == 14);
            if (c == 14) set_instr(I_LW);
            case (c)
                0, 6, 22:                e = 19'd0;
                1, 2, 3, 4, 7, 8, 9, 23: e = v_fetch(0);
                5, 21:                   e = v_fault();
                10, 14:                  e = v_fetch(1);
                11, 15:                  e = v_dec();
                12:                      e = ev(2, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0);
                13:                      e = ev(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
                16:                      e = ev(2, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0);
                default:                 e = ev(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            exp_q.push_back(e);
            @(negedge clk);
            got = obs();
            e = exp_q.pop_front();
            compared++;
            if (got !== e) begin mismatched++; $display("FAIL timeout[%0d] got %h expected %h", c, got, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [18:0] e, got;
        for (int k = 0; k < 2; k++) begin
            set_instr(k == 0 ? I_LW : I_SW);
            for (int c = 0; c < 6; c++) begin
                resetn      = (c != 4);
                bus.mem_ack = (c == 0 || c == 4);
                case (c)
                    0:       e = v_fetch(1);
                    1:       e = v_dec();
                    2:       e = ev(2, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0);
                    3:       e = ev(3, 1, k, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                    4:       e = 19'd0;
                    default: e = v_fetch(0);
                endcase
                exp_q.push_back(e);
                @(negedge clk);
                got = obs();
                e = exp_q.pop_front();
                compared++;
                if (got !== e) begin mismatched++; $display("FAIL resetmid%0d[%0d] got %h expected %h", k, c, got, e); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_timeout_disabled();
        logic [18:0] e, got;
        bus0.mem_ack = 1'b0;
        resetn0 = 1'b0;
        @(posedge clk); #1;
        resetn0 = 1'b1;
        for (int c = 1; c <= 1000; c++) begin
            if (c % 250 == 0) begin
                e = v_fetch(0);
                exp_q.push_back(e);
                @(negedge clk);
                got = obs0();
                e = exp_q.pop_front();
                compared++;
                if (got !== e) begin mismatched++; $display("FAIL no_timeout[%0d] got %h expected %h", c, got, e); end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        resetn       = 1'b0;
        resetn0      = 1'b0;
        bus.mem_ack  = 1'b0;
        bus.alu_zero = 1'b0;
        set_instr(I_ADD);
        {bus0.dec_valid, bus0.memtoreg, bus0.memwrite, bus0.alusrc, bus0.regwrite, bus0.jump,
         bus0.branchtype, bus0.aluop} = I_ADD;
        bus0.alu_zero = 1'b0;
        bus0.mem_ack  = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_fault();
        test_timeout();
        test_reset_mid();
        test_timeout_disabled();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
